div: RTL and testbench
======================

Name: div

Overview:
- Sequential signed 32-bit divider serving the CPU's `div` instruction.
- Responder side of the start/result handshake the control unit drives through `div_start`.
- Produces `div_hi_out` (remainder) and `div_lo_out` (quotient), which the HI/LO source mux selects when HiLoSrc chooses the divider.
- Iterative restoring division on magnitudes, then sign fix; flags divide-by-zero so the control unit can raise the exception.

Parameters:
- DATA_W, 32, operand/result width; iteration count equals DATA_W.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- A  input  DATA_W  dividend, from A register output
- B  input  DATA_W  divisor, from B register output
- start  input  1  request; sampled only in IDLE
- hi  output  DATA_W  remainder (MIPS HI)
- lo  output  DATA_W  quotient (MIPS LO)
- done  output  1  one-cycle pulse: result valid / op finished
- div_zero  output  1  one-cycle pulse with done when B==0
- busy  output  1  high from the cycle after start is accepted until done

Behaviour:
- Reset (async, any state):
  - hi=0, lo=0, done=0, div_zero=0, busy=0; state=IDLE; internal regs cleared.
  - Reset mid-CALC abandons the operation; no done is produced.
- States: IDLE, CALC, FIN.
- IDLE:
  - start=1 at edge E0 latches |A|, |B|, sign(A), sign(B); busy=1.
  - B==0: go to FIN with div_zero set. Quotient/remainder regs are not updated.
  - Otherwise: go to CALC with iteration counter=0, partial remainder=0, quotient reg=|A|.
- CALC, one iteration per cycle:
  - Shift {rem,quo} left 1.
  - Trial = rem - |B| (DATA_W+1 bits).
  - If trial is non-negative: rem=trial and quo LSB=1; else quo LSB=0.
  - After DATA_W iterations (edge E32) go to FIN.
- FIN (one cycle, at edge E33):
  - Division: lo = sign(A)^sign(B) ? -quo : quo; hi = sign(A) ? -rem : rem. Remainder takes the dividend's sign.
  - done=1, busy=0 for exactly one cycle, then return to IDLE.
  - Divide-by-zero path: done=1 and div_zero=1 after E1; hi/lo retain their previous values.
- Latency: start sampled at E0 → done high after E33 (DATA_W+1 cycles). Divide-by-zero: done after E1.
- hi/lo hold their value from the last successful op until the next successful op or reset.
- start while busy or in FIN is ignored; operand changes on A/B after E0 have no effect.
- start held high continuously: a new op is accepted on the first IDLE cycle after FIN.
- Overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No overflow flag is raised.
- All arithmetic is modulo 2^DATA_W. Magnitude of 0x80000000 is 0x80000000 (unsigned).

Optional Feature:
- Macro: DIV_FAST_EN.
- Defined: in IDLE, when B!=0 and |A|<|B| (including A==0), skip CALC and go directly to FIN with quo=0, rem=|A|. done is asserted after E1 with lo=0, hi=A.
- Not defined: every non-zero-divisor op takes the full DATA_W+1 cycles. Results are identical either way; only latency differs.

Test Plan:
- A=7, B=2, start pulse → done pulse after E33, lo=0x00000003, hi=0x00000001, div_zero=0.
- A=0xFFFFFFF9 (-7), B=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also A=7, B=0xFFFFFFFE → lo=0xFFFFFFFD, hi=0x00000001.
- Prior result lo=3, hi=1; then A=5, B=0 → done and div_zero high for one cycle after E1; lo=3, hi=1 unchanged; busy low after that cycle.
- A=0x80000000, B=0xFFFFFFFF → after E33, lo=0x80000000, hi=0x00000000.
- Start A=100, B=7; assert reset at E10 → hi=lo=0, busy=0 immediately, no done. Release reset, start A=100, B=7 → lo=14, hi=2 after E33.
- Start A=9, B=3; pulse start with A=50, B=5 at E5 → single done at E33 with lo=3, hi=0. With DIV_FAST_EN: A=3, B=9 → done after E1, lo=0, hi=3.

Source files
------------

// File: rtl/div.sv
// rtl/div.sv - sequential signed restoring divider (quotient to lo, remainder to hi)
//
// Purpose:
//   Iterative signed DATA_W-bit divider for the CPU div instruction. Operand
//   magnitudes are latched when start is accepted in IDLE. The unsigned quotient
//   and remainder are produced one bit per cycle in CALC. The signs are
//   restored in FIN. The quotient takes sign(A)^sign(B). The remainder takes
//   the sign of the dividend.
//
// Optional feature:
//   DIV_FAST_EN - when defined, an op with |A| < |B| (and B != 0) skips CALC
//   and finishes after one cycle. The results are identical; only the latency
//   changes.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset
//   A        in   dividend (sampled only when start is accepted)
//   B        in   divisor  (sampled only when start is accepted)
//   start    in   operation request, honoured only in IDLE
//   hi       out  remainder of the last successful op
//   lo       out  quotient of the last successful op
//   done     out  one-cycle pulse when an op finishes
//   div_zero out  one-cycle pulse alongside done when B was zero
//   busy     out  high from the cycle after acceptance until done
module div #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              start,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              done,
  output logic              div_zero,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIN
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   rem_q;
  logic [DATA_W-1:0]   quo_q;
  logic [DATA_W-1:0]   absb_q;
  logic                sign_a_q;
  logic                sign_b_q;
  logic                dz_q;

  // Magnitudes wrap modulo 2^DATA_W, so the most negative value maps onto itself.
  // Read as unsigned, that value is the correct magnitude.
  logic [DATA_W-1:0]   abs_a;
  logic [DATA_W-1:0]   abs_b;
  assign abs_a = A[DATA_W-1] ? -A : A;
  assign abs_b = B[DATA_W-1] ? -B : B;

  // One restoring step: shift the next dividend bit into the partial remainder.
  // Then try to subtract the divisor. The partial remainder stays below |B|,
  // which is at most 2^(DATA_W-1). The shifted value therefore fits in DATA_W
  // bits, and the extra MSB of the trial works as a borrow/sign bit.
  logic [DATA_W:0]     shifted;
  logic [DATA_W:0]     trial;
  logic                trial_ok;
  assign shifted  = {rem_q, quo_q[DATA_W-1]};
  assign trial    = shifted - {1'b0, absb_q};
  assign trial_ok = ~trial[DATA_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      absb_q   <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dz_q     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            absb_q   <= abs_b;
            sign_a_q <= A[DATA_W-1];
            sign_b_q <= B[DATA_W-1];
            busy     <= 1'b1;
            cnt_q    <= '0;
            if (B == '0) begin
              // The quotient and remainder registers are left untouched.
              // FIN then leaves hi/lo as they are.
              dz_q    <= 1'b1;
              state_q <= S_FIN;
            end
`ifdef DIV_FAST_EN
            else if (abs_a < abs_b) begin
              dz_q    <= 1'b0;
              quo_q   <= '0;
              rem_q   <= abs_a;
              state_q <= S_FIN;
            end
`endif
            else begin
              dz_q    <= 1'b0;
              rem_q   <= '0;
              quo_q   <= abs_a;
              state_q <= S_CALC;
            end
          end
        end

        S_CALC: begin
          rem_q <= trial_ok ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
          quo_q <= {quo_q[DATA_W-2:0], trial_ok};
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_q <= S_FIN;
          end
        end

        S_FIN: begin
          if (dz_q) begin
            div_zero <= 1'b1;
          end else begin
            lo <= (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
            hi <= sign_a_q ? -rem_q : rem_q;
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          dz_q    <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - directed self-checking bench for the div block
module tb_div;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic        start;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;
  logic        div_zero;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  div #(.DATA_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .start    (start),
    .hi       (hi),
    .lo       (lo),
    .done     (done),
    .div_zero (div_zero),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Called #1 after an edge with the DUT idle. Returns the number of edges after
  // E0 until done is seen (33 for a full op, 1 for a short one).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D;
    check("busy_after_start", 32'(busy), 32'd1);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("busy_at_done", 32'(busy), 32'd0);
  endtask

  int lat;
  int nd;
  int first;
  int second;
  logic [31:0] lo_at2;
  logic [31:0] hi_at2;
  int fast_lat;

  initial begin
    reset = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dz", 32'(div_zero), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(32'd7, 32'd2, lat);
    check("p7_2_lat", 32'(lat), 32'd33);
    check("p7_2_lo", lo, 32'd3);
    check("p7_2_hi", hi, 32'd1);
    check("p7_2_dz", 32'(div_zero), 32'd0);
    @(posedge clk); #1;
    check("p7_2_done_pulse", 32'(done), 32'd0);

    run_op(32'hFFFF_FFF9, 32'd2, lat);
    check("m7_2_lo", lo, 32'hFFFF_FFFD);
    check("m7_2_hi", hi, 32'hFFFF_FFFF);

    run_op(32'd7, 32'hFFFF_FFFE, lat);
    check("p7_m2_lo", lo, 32'hFFFF_FFFD);
    check("p7_m2_hi", hi, 32'd1);

    run_op(32'd7, 32'd2, lat);
    run_op(32'd5, 32'd0, lat);
    check("dz_lat", 32'(lat), 32'd1);
    check("dz_flag", 32'(div_zero), 32'd1);
    check("dz_lo_kept", lo, 32'd3);
    check("dz_hi_kept", hi, 32'd1);
    @(posedge clk); #1;
    check("dz_done_low", 32'(done), 32'd0);
    check("dz_flag_low", 32'(div_zero), 32'd0);
    check("dz_busy_low", 32'(busy), 32'd0);

    run_op(32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("ovf_lat", 32'(lat), 32'd33);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'd0);

    // Reset in the middle of CALC: everything is cleared and no done appears.
    A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_hi", hi, 32'd0);
    check("mid_rst_lo", lo, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    nd = 0;
    repeat (3) begin @(posedge clk); #1; if (done) nd++; end
    reset = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done) nd++; end
    check("mid_rst_no_done", 32'(nd), 32'd0);
    run_op(32'd100, 32'd7, lat);
    check("p100_7_lat", 32'(lat), 32'd33);
    check("p100_7_lo", lo, 32'd14);
    check("p100_7_hi", hi, 32'd2);

    // A start pulse during CALC is ignored and the first operands win.
    A = 32'd9; B = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    A = 32'd50; B = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nd = 0; first = 0;
    for (int c = 6; c <= 45; c++) begin
      @(posedge clk); #1;
      if (done) begin
        nd++;
        if (first == 0) first = c;
      end
    end
    check("ign_done_count", 32'(nd), 32'd1);
    check("ign_done_edge", 32'(first), 32'd33);
    check("ign_lo", lo, 32'd3);
    check("ign_hi", hi, 32'd0);

`ifdef DIV_FAST_EN
    fast_lat = 1;
`else
    fast_lat = 33;
`endif
    run_op(32'd3, 32'd9, lat);
    check("p3_9_lat", 32'(lat), 32'(fast_lat));
    check("p3_9_lo", lo, 32'd0);
    check("p3_9_hi", hi, 32'd3);
    run_op(32'hFFFF_FFFD, 32'd9, lat);
    check("m3_9_lat", 32'(lat), 32'(fast_lat));
    check("m3_9_lo", lo, 32'd0);
    check("m3_9_hi", hi, 32'hFFFF_FFFD);
    run_op(32'd0, 32'd5, lat);
    check("z_5_lo", lo, 32'd0);
    check("z_5_hi", hi, 32'd0);

    // With start held high, the next op is accepted on the IDLE cycle right after FIN.
    A = 32'd20; B = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    first = 0; second = 0; lo_at2 = '0; hi_at2 = '0;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      if (done) begin
        if (first == 0) first = c;
        else if (second == 0) begin
          second = c; lo_at2 = lo; hi_at2 = hi;
        end
      end
    end
    start = 1'b0;
    check("held_first", 32'(first), 32'd33);
    check("held_second", 32'(second), 32'd67);
    check("held_lo", lo_at2, 32'd6);
    check("held_hi", hi_at2, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
